// File: rtl/seq_add_pkg.sv
// ---------------------------------------------------------------------------
// seq_add_pkg
//   Shared types and helpers for the multi-cycle chunked adder.
//   - state_t : controller states (IDLE, BUSY, DONE)
//   - nchunk  : number of clock cycles (chunks) per addition
// ---------------------------------------------------------------------------
package seq_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage : seq_add_pkg

// File: rtl/chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder
//   Combinational CHUNK-bit adder slice used once per cycle by seq_chunk_adder.
//   Ports:
//     a, b   in  CHUNK  operand slices
//     cin    in  1      carry into bit 0 of the slice
//     s      out CHUNK  slice sum
//     cout   out 1      carry out of the top bit of the slice
//     c_msb  out 1      carry into the top bit of the slice (only with
//                       SEQ_ADD_OVERFLOW_EN defined; feeds signed overflow)
// ---------------------------------------------------------------------------
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
`ifdef SEQ_ADD_OVERFLOW_EN
    ,
    output logic             c_msb
`endif
);

    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

`ifdef SEQ_ADD_OVERFLOW_EN
    // The sum bit is a ^ b ^ carry_in, so the carry into the top bit can be
    // recovered without a second adder.
    assign c_msb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
`endif

endmodule : chunk_adder

// File: rtl/seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder
//   Multi-cycle adder: a + b + cin over WIDTH bits, CHUNK bits per clock,
//   LSB chunk first, carry held in a register between chunks.
//   Optional feature macro: SEQ_ADD_OVERFLOW_EN (adds the overflow output).
//   Ports:
//     clk       in   1      rising-edge clock
//     rst_n     in   1      asynchronous active-low reset
//     start     in   1      request, honoured only in IDLE or DONE
//     a, b      in   WIDTH  operands, captured on the accepting edge
//     cin       in   1      carry in, captured on the accepting edge
//     busy      out  1      chunks being computed
//     done      out  1      one-cycle pulse, result newly valid
//     sum       out  WIDTH  last completed sum (held)
//     cout      out  1      carry out of bit WIDTH-1 (held)
//     overflow  out  1      signed overflow (held; SEQ_ADD_OVERFLOW_EN only)
// ---------------------------------------------------------------------------
module seq_chunk_adder
    import seq_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_ADD_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, work_q, work_d;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      idx_base;
    logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
    logic             c_out_chunk;
    logic             accept;
    logic             last_chunk;
`ifdef SEQ_ADD_OVERFLOW_EN
    logic             c_msb_chunk;
`endif

    // A new request is only honoured outside BUSY; a start during BUSY is dropped.
    assign accept     = start && (state_q != BUSY);
    assign last_chunk = (state_q == BUSY) && (idx_q == LAST_IDX);

    // Single adder slice, operand chunks selected by the current index.
    assign idx_base = 32'(idx_q) * 32'(CHUNK);
    assign a_chunk  = CHUNK'(a_q >> idx_base);
    assign b_chunk  = CHUNK'(b_q >> idx_base);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry_q),
        .s     (s_chunk),
        .cout  (c_out_chunk)
`ifdef SEQ_ADD_OVERFLOW_EN
        ,
        .c_msb (c_msb_chunk)
`endif
    );

    // Working sum with the current chunk merged in; on the last chunk this is
    // the complete result, published straight to sum without an extra cycle.
    always_comb begin
        work_d = (work_q & ~(CHUNK_MASK << idx_base)) | (WIDTH'(s_chunk) << idx_base);
    end

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: flops are always written with <= so every register samples
            // pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = start ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
`ifdef SEQ_ADD_OVERFLOW_EN
            overflow <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
        end else if (state_q == BUSY) begin
            work_q  <= work_d;
            carry_q <= c_out_chunk;
            idx_q   <= idx_q + 1'b1;
            if (last_chunk) begin
                sum      <= work_d;
                cout     <= c_out_chunk;
`ifdef SEQ_ADD_OVERFLOW_EN
                overflow <= c_msb_chunk ^ c_out_chunk;
`endif
            end
        end
    end

endmodule : seq_chunk_adder

// File: tb/tb_seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_chunk_adder
//   Self-checking bench for seq_chunk_adder. Three instances cover the
//   WIDTH/CHUNK shapes of interest: 8/4 (main), 8/2 and 4/4. Expected values
//   come from plain integer arithmetic on the captured operands.
//   The overflow port is exercised only when SEQ_ADD_OVERFLOW_EN is defined.
// ---------------------------------------------------------------------------
module tb_seq_chunk_adder;

    localparam int N84 = 2;   // 8/4 instance: cycles per addition
    localparam int N82 = 4;   // 8/2 instance
    localparam int N44 = 1;   // 4/4 instance

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] a8, b8, sum8;
    logic       cin8, start8, busy8, done8, cout8;
    logic [7:0] a2, b2, sum2;
    logic       cin2, start2, busy2, done2, cout2;
    logic [3:0] a4, b4, sum4;
    logic       cin4, start4, busy4, done4, cout4;
`ifdef SEQ_ADD_OVERFLOW_EN
    logic       ovf8, ovf2, ovf4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut84 (
`ifdef SEQ_ADD_OVERFLOW_EN
        .overflow (ovf8),
`endif
        .clk (clk), .rst_n (rst_n), .start (start8), .a (a8), .b (b8), .cin (cin8),
        .busy (busy8), .done (done8), .sum (sum8), .cout (cout8)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut82 (
`ifdef SEQ_ADD_OVERFLOW_EN
        .overflow (ovf2),
`endif
        .clk (clk), .rst_n (rst_n), .start (start2), .a (a2), .b (b2), .cin (cin2),
        .busy (busy2), .done (done2), .sum (sum2), .cout (cout2)
    );

    seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut44 (
`ifdef SEQ_ADD_OVERFLOW_EN
        .overflow (ovf4),
`endif
        .clk (clk), .rst_n (rst_n), .start (start4), .a (a4), .b (b4), .cin (cin4),
        .busy (busy4), .done (done4), .sum (sum4), .cout (cout4)
    );

    // ---------------- reference model ----------------
    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return 9'(t);
    endfunction

    // Two's-complement overflow: operands share a sign the result does not.
    function automatic logic ref_ovf8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] s);
        return (x[7] == y[7]) && (s[7] != x[7]);
    endfunction

    // ---------------- helpers (stimulus/timing only) ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait for done on the 8/4 instance, counting edges; bounded.
    task automatic wait_done84(output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            if (done8) seen = 1'b1;
        end
    endtask

    task automatic start84(input logic [7:0] x, input logic [7:0] y, input logic c);
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
        start2 = 0; a2 = '0; b2 = '0; cin2 = 0;
        start4 = 0; a4 = '0; b4 = '0; cin4 = 0;
        #3;
        n_checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_84: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
        end
        n_checks++;
        if ({busy2, done2, sum2, cout2} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_82: got busy=%b done=%b sum=%h cout=%b, want all 0", busy2, done2, sum2, cout2);
        end
        n_checks++;
        if ({busy4, done4, sum4, cout4} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_44: got busy=%b done=%b sum=%h cout=%b, want all 0", busy4, done4, sum4, cout4);
        end
`ifdef SEQ_ADD_OVERFLOW_EN
        n_checks++;
        if ({ovf8, ovf2, ovf4} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b%b%b, want 000", ovf8, ovf2, ovf4);
        end
`endif
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_chunk;
        a4 = 4'b1101; b4 = 4'b0110; cin4 = 1'b0; start4 = 1'b1;
        tick();                       // E0
        start4 = 1'b0;
        n_checks++;
        if (busy4 !== 1'b1 || done4 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: got busy=%b done=%b, want 1 0", busy4, done4);
        end
        tick();                       // E1 = E(N44)
        n_checks++;
        if (done4 !== 1'b1 || sum4 !== 4'b0011 || cout4 !== 1'b1 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done=%b busy=%b sum=%b cout=%b, want 1 0 0011 1 after %0d edge",
                     done4, busy4, sum4, cout4, N44);
        end
        tick();
        n_checks++;
        if (done4 !== 1'b0 || sum4 !== 4'b0011 || cout4 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold: got done=%b sum=%b cout=%b, want 0 0011 1", done4, sum4, cout4);
        end
    endtask

    task automatic test_chunk2;
        int edges;
        int busy_cnt;
        a2 = 8'hFF; b2 = 8'h01; cin2 = 1'b0; start2 = 1'b1;
        tick();                       // E0
        start2 = 1'b0;
        edges = 0; busy_cnt = 0;
        while (!done2 && edges < 20) begin
            if (busy2) busy_cnt++;
            tick();
            edges++;
        end
        n_checks++;
        if (edges != N82 || busy_cnt != N82) begin
            n_fail++;
            $display("FAIL chunk2_timing: got done after %0d edges, busy %0d cycles, want %0d and %0d",
                     edges, busy_cnt, N82, N82);
        end
        n_checks++;
        if (sum2 !== 8'h00 || cout2 !== 1'b1) begin
            n_fail++;
            $display("FAIL chunk2_result: got sum=%h cout=%b, want 00 1", sum2, cout2);
        end
`ifdef SEQ_ADD_OVERFLOW_EN
        n_checks++;
        if (ovf2 !== 1'b0) begin
            n_fail++;
            $display("FAIL chunk2_ovf: got %b, want 0", ovf2);
        end
`endif
        tick();
    endtask

    task automatic test_overflow;
        int  cyc;
        bit  seen;
        start84(8'h7F, 8'h01, 1'b0);
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_busy: got busy=%b, want 1", busy8);
        end
        wait_done84(cyc, seen);
        n_checks++;
        if (!seen || cyc != N84 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_timing: got seen=%0b edges=%0d busy=%b, want 1 %0d 0", seen, cyc, busy8, N84);
        end
        n_checks++;
        if (sum8 !== 8'h80 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_result: got sum=%h cout=%b, want 80 0", sum8, cout8);
        end
`ifdef SEQ_ADD_OVERFLOW_EN
        n_checks++;
        if (ovf8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b, want 1", ovf8);
        end
`endif
        tick();
        n_checks++;
        if (done8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pulse: done still %b one cycle later, want 0", done8);
        end
    endtask

    task automatic test_ignore_start;
        int dones;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1; start8 = 1'b1;
        tick();                       // E0: accepted
        a8 = 8'hFF;                   // start still high while BUSY
        tick();                       // E1: must be ignored
        start8 = 1'b0; a8 = 8'h00;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done8) begin
                dones++;
                n_checks++;
                if (sum8 !== 8'h31 || cout8 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_result: got sum=%h cout=%b, want 31 0", sum8, cout8);
                end
            end
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL ignore_dones: got %0d done pulses, want 1", dones);
        end
    endtask

    task automatic test_reset_abort;
        int  dones;
        int  cyc;
        bit  seen;
        start84(8'h0F, 8'h01, 1'b0);  // now just after E0
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, sum8, cout8} !== 11'd0) begin
            n_fail++;
            $display("FAIL abort_clear: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
        end
        @(posedge clk);               // E1 with reset held
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done8) dones++;
        end
        n_checks++;
        if (dones != 0 || sum8 !== 8'h00 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: got dones=%0d sum=%h busy=%b, want 0 00 0", dones, sum8, busy8);
        end
        start84(8'h03, 8'h04, 1'b0);
        wait_done84(cyc, seen);
        n_checks++;
        if (!seen || cyc != N84 || sum8 !== 8'h07 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_restart: got seen=%0b edges=%0d sum=%h cout=%b, want 1 %0d 07 0",
                     seen, cyc, sum8, cout8, N84);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit seen;
        a8 = 8'h05; b8 = 8'h06; cin8 = 1'b0; start8 = 1'b1;
        tick();                       // E0, start kept high throughout
        wait_done84(cyc, seen);
        n_checks++;
        if (!seen || cyc != N84 || sum8 !== 8'h0B) begin
            n_fail++;
            $display("FAIL b2b_first: got seen=%0b edges=%0d sum=%h, want 1 %0d 0B", seen, cyc, sum8, N84);
        end
        a8 = 8'h01; b8 = 8'h01;       // new operands during the DONE cycle
        tick();                       // accepting edge straight out of DONE
        start8 = 1'b0;
        n_checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'h0B) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b done=%b sum=%h, want 1 0 0B", busy8, done8, sum8);
        end
        wait_done84(cyc, seen);
        n_checks++;
        if (!seen || cyc != N84 || sum8 !== 8'h02 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: got seen=%0b edges=%0d sum=%h cout=%b, want 1 %0d 02 0",
                     seen, cyc, sum8, cout8, N84);
        end
        tick();
    endtask

    task automatic test_random;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] exp;
        int         cyc;
        bit         seen;
        int         gap;
        for (int it = 0; it < 30; it++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = ref_add8(ra, rb, rc);
            a8 = ra; b8 = rb; cin8 = rc; start8 = 1'b1;
            tick();                   // accepted
            cyc = 0; seen = 1'b0;
            // Scramble operands and start while BUSY: none of it may matter.
            while (!seen && cyc < 20) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'($urandom);
                tick();
                cyc++;
                if (done8) seen = 1'b1;
            end
            start8 = 1'b0;
            n_checks++;
            if (!seen || cyc != N84 || {cout8, sum8} !== exp) begin
                n_fail++;
                $display("FAIL rand84_%0d: %h+%h+%b got seen=%0b edges=%0d cout,sum=%h, want %0d edges %h",
                         it, ra, rb, rc, seen, cyc, {cout8, sum8}, N84, exp);
            end
`ifdef SEQ_ADD_OVERFLOW_EN
            n_checks++;
            if (ovf8 !== ref_ovf8(ra, rb, exp[7:0])) begin
                n_fail++;
                $display("FAIL rand84_ovf_%0d: %h+%h+%b got %b, want %b", it, ra, rb, rc, ovf8, ref_ovf8(ra, rb, exp[7:0]));
            end
`endif
            gap = 1 + int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            n_checks++;
            if (done8 !== 1'b0 || {cout8, sum8} !== exp) begin
                n_fail++;
                $display("FAIL rand84_hold_%0d: got done=%b cout,sum=%h, want 0 %h", it, done8, {cout8, sum8}, exp);
            end
        end

        for (int it = 0; it < 10; it++) begin
            int edges;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = ref_add8(ra, rb, rc);
            a2 = ra; b2 = rb; cin2 = rc; start2 = 1'b1;
            tick();
            start2 = 1'b0;
            a2 = ~ra; b2 = ~rb;
            edges = 0;
            while (!done2 && edges < 20) begin
                tick();
                edges++;
            end
            n_checks++;
            if (edges != N82 || {cout2, sum2} !== exp) begin
                n_fail++;
                $display("FAIL rand82_%0d: %h+%h+%b got edges=%0d cout,sum=%h, want %0d %h",
                         it, ra, rb, rc, edges, {cout2, sum2}, N82, exp);
            end
`ifdef SEQ_ADD_OVERFLOW_EN
            n_checks++;
            if (ovf2 !== ref_ovf8(ra, rb, exp[7:0])) begin
                n_fail++;
                $display("FAIL rand82_ovf_%0d: got %b, want %b", it, ovf2, ref_ovf8(ra, rb, exp[7:0]));
            end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_chunk2();
        test_overflow();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule : tb_seq_chunk_adder
